memory_wait_ctrl: RTL and testbench

- Parametrised successor to the basic single-port RAM: synchronous RAM behind a request/acknowledge handshake.
- Adds programmable wait states, per-byte write lanes, a registered read port, an optional partial depth with out-of-range error reporting, and a busy indicator.
- Sits between the CPU memory-stage / fetch logic and the storage array. It emulates slow memory so pipeline stall logic can be exercised.

---
 rtl/memory_wait_ctrl.sv | 139 +++++++++++++
 tb/tb_memory_wait_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_wait_ctrl.sv
// Single-port synchronous RAM behind a req/ack handshake with programmable wait
// states, byte-lane writes, registered read data and out-of-range error pulse.
//
// state  | meaning
// IDLE   | waiting for req; request fields latched on the accepting edge
// WAIT   | counting down the programmed wait states
// DONE   | array access completed on the entering edge; ack (and err) high
module memory_wait_ctrl #(
  parameter int unsigned DATAWIDTH   = 16,
  parameter int unsigned ADDRWIDTH   = 20,
  parameter int unsigned DEPTH       = 2**ADDRWIDTH,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic                   we,
  input  logic [ADDRWIDTH-1:0]   addr,
  input  logic [DATAWIDTH/8-1:0] be,
  input  logic [DATAWIDTH-1:0]   wdata,
  output logic [DATAWIDTH-1:0]   rdata,
  output logic                   ack,
  output logic                   err,
  output logic                   busy
);

  localparam int NBYTES = DATAWIDTH / 8;
  localparam int IDXW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  generate
    if ((DATAWIDTH % 8) != 0 || DATAWIDTH == 0) begin : g_bad_width
      $error("memory_wait_ctrl: DATAWIDTH must be a non-zero multiple of 8");
    end
    if (WAIT_STATES > 15) begin : g_bad_wait
      $error("memory_wait_ctrl: WAIT_STATES must be 0..15");
    end
    if (DEPTH < 1 || DEPTH > 2**ADDRWIDTH) begin : g_bad_depth
      $error("memory_wait_ctrl: DEPTH must be 1..2**ADDRWIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                 state, state_nxt;
  logic [3:0]             cnt;
  logic                   we_q;
  logic [ADDRWIDTH-1:0]   addr_q;
  logic [NBYTES-1:0]      be_q;
  logic [DATAWIDTH-1:0]   wdata_q;
  logic                   oor_q;
  logic [DATAWIDTH-1:0]   mem [DEPTH];

  logic                   accept;
  logic                   complete;
  logic                   addr_oor;
  logic                   op_we;
  logic                   op_oor;
  logic [IDXW-1:0]        op_idx;
  logic [NBYTES-1:0]      op_be;
  logic [DATAWIDTH-1:0]   op_wdata;

  assign accept   = (state == S_IDLE) && req;
  assign complete = (state != S_DONE) && (state_nxt == S_DONE);
  assign addr_oor = (32'(addr) >= DEPTH);

  // With zero wait states the access completes on the accepting edge, so the
  // live inputs are used instead of the not-yet-latched copies.
  always_comb begin
    if (state == S_IDLE) begin
      op_we    = we;
      op_oor   = addr_oor;
      op_idx   = addr[IDXW-1:0];
      op_be    = be;
      op_wdata = wdata;
    end else begin
      op_we    = we_q;
      op_oor   = oor_q;
      op_idx   = addr_q[IDXW-1:0];
      op_be    = be_q;
      op_wdata = wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req) state_nxt = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
      S_WAIT:  if (cnt == 4'd0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ack  = (state == S_DONE);
    err  = (state == S_DONE) && oor_q;
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      rdata   <= '0;
    end else begin
      if (accept) begin
        cnt     <= CNT_INIT;
        we_q    <= we;
        addr_q  <= addr;
        be_q    <= be;
        wdata_q <= wdata;
        oor_q   <= addr_oor;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (complete && !op_we) rdata <= op_oor ? '0 : mem[op_idx];
    end
  end

  // Array has no reset; rst_n gating stops a zero-wait write accepted during reset.
  always_ff @(posedge clk) begin
    if (rst_n && complete && op_we && !op_oor) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (op_be[i]) mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_memory_wait_ctrl.sv
// Directed bench for memory_wait_ctrl: table of transactions on a 2-wait-state
// instance plus hand sequences for held req, reset abort and a 0-wait instance.
module tb_memory_wait_ctrl;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [3:0]  addr = '0;
  logic [1:0]  be = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        ack, err, busy;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [3:0]  addr0 = '0;
  logic [1:0]  be0 = '0;
  logic [15:0] wdata0 = '0;
  logic [15:0] rdata0;
  logic        ack0, err0, busy0;

  int n_cmp = 0;
  int n_err = 0;

  memory_wait_ctrl #(.DATAWIDTH(16), .ADDRWIDTH(4), .DEPTH(12), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
  );

  memory_wait_ctrl #(.DATAWIDTH(16), .ADDRWIDTH(4), .DEPTH(12), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .addr(addr0), .be(be0),
    .wdata(wdata0), .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] init_word(input int i);
    return {8'(i), 8'(i)};
  endfunction

  function automatic logic [15:0] final_word(input int i);
    case (i)
      3:       return 16'hA522;
      4:       return 16'h0044;
      default: return init_word(i);
    endcase
  endfunction

  // Starts and ends on a falling edge; inputs are scrambled after the accepting edge.
  task automatic run_txn(input logic t_we, input logic [3:0] t_addr, input logic [1:0] t_be,
                         input logic [15:0] t_wdata, input logic [15:0] exp_rd,
                         input logic exp_e, input string nm);
    int lat;
    bit seen;
    req = 1'b1; we = t_we; addr = t_addr; be = t_be; wdata = t_wdata;
    lat = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      req = 1'b0; we = ~t_we; addr = 4'($urandom); be = 2'($urandom); wdata = 16'($urandom);
      if (ack) begin
        seen = 1;
      end else begin
        chk({nm, " busy in wait"}, 32'(busy), 1);
        chk({nm, " err in wait"}, 32'(err), 0);
        if (t_we) chk({nm, " rdata held"}, 32'(rdata), 32'(exp_rd));
      end
    end
    if (!seen) begin
      chk({nm, " ack timeout"}, 32'(ack), 1);
    end else begin
      chk({nm, " latency"}, 32'(lat), 32'(WS + 1));
      chk({nm, " busy at ack"}, 32'(busy), 1);
      chk({nm, " err"}, 32'(err), 32'(exp_e));
      chk({nm, " rdata"}, 32'(rdata), 32'(exp_rd));
    end
    @(negedge clk);
    chk({nm, " ack drop"}, 32'(ack), 0);
    chk({nm, " busy drop"}, 32'(busy), 0);
    chk({nm, " err drop"}, 32'(err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, starts, last_k, first_k;
    logic busy_prev;

    tbl[0]  = '{1'b1, 4'd3,  2'b11, 16'hA5C3, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 4'd3,  2'b00, 16'h0000, 16'hA5C3, 1'b0};
    tbl[2]  = '{1'b1, 4'd3,  2'b01, 16'h1122, 16'hA5C3, 1'b0};
    tbl[3]  = '{1'b0, 4'd3,  2'b11, 16'h0000, 16'hA522, 1'b0};
    tbl[4]  = '{1'b1, 4'd4,  2'b11, 16'h4444, 16'hA522, 1'b0};
    tbl[5]  = '{1'b1, 4'd4,  2'b10, 16'h00FF, 16'hA522, 1'b0};
    tbl[6]  = '{1'b0, 4'd4,  2'b00, 16'h0000, 16'h0044, 1'b0};
    tbl[7]  = '{1'b1, 4'd13, 2'b11, 16'hFFFF, 16'h0044, 1'b1};
    tbl[8]  = '{1'b0, 4'd13, 2'b11, 16'h0000, 16'h0000, 1'b1};
    tbl[9]  = '{1'b1, 4'd5,  2'b00, 16'h0F0F, 16'h0000, 1'b0};
    tbl[10] = '{1'b0, 4'd5,  2'b00, 16'h0000, 16'h0505, 1'b0};
    tbl[11] = '{1'b0, 4'd11, 2'b00, 16'h0000, 16'h0B0B, 1'b0};
    tbl[12] = '{1'b0, 4'd12, 2'b00, 16'h0000, 16'h0000, 1'b1};

    repeat (2) @(negedge clk);
    chk("reset ack", 32'(ack), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset err", 32'(err), 0);
    chk("reset rdata", 32'(rdata), 0);
    chk("reset ack0", 32'(ack0), 0);
    chk("reset busy0", 32'(busy0), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_txn(1'b1, 4'(i), 2'b11, init_word(i), 16'h0000, 1'b0, "init");

    for (int v = 0; v < 13; v++)
      run_txn(tbl[v].we, tbl[v].addr, tbl[v].be, tbl[v].wdata,
              tbl[v].exp_rdata, tbl[v].exp_err, $sformatf("vec%0d", v));

    // req held high, alternating reads of 3 and 4
    req = 1'b1; we = 1'b0; addr = 4'd3; be = 2'b00;
    acks = 0; starts = 0; last_k = -1; first_k = -1; busy_prev = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (busy && !busy_prev) starts++;
      busy_prev = busy;
      if (ack) begin
        acks++;
        chk("hold rdata", 32'(rdata), (acks % 2 == 1) ? 32'hA522 : 32'h0044);
        chk("hold err", 32'(err), 0);
        if (last_k >= 0) chk("hold ack spacing", 32'(k - last_k), 32'(WS + 2));
        else first_k = k;
        last_k = k;
        addr = (addr == 4'd3) ? 4'd4 : 4'd3;
        if (acks == 4) req = 1'b0;
      end
    end
    chk("hold first ack", 32'(first_k), 32'(WS + 1));
    chk("hold ack count", 32'(acks), 4);
    chk("hold accepted count", 32'(starts), 4);

    // reset while a write to addr 5 sits in WAIT
    req = 1'b1; we = 1'b1; addr = 4'd5; be = 2'b11; wdata = 16'h0F0F;
    @(negedge clk);
    req = 1'b0;
    chk("abort busy before reset", 32'(busy), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort ack", 32'(ack), 0);
    chk("abort busy", 32'(busy), 0);
    chk("abort err", 32'(err), 0);
    chk("abort rdata", 32'(rdata), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort ack in reset", 32'(ack), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(1'b0, 4'd5, 2'b00, 16'h0000, 16'h0505, 1'b0, "after abort read5");

    // zero-wait instance
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; be0 = 2'b11; wdata0 = 16'hA5C3;
    @(negedge clk);
    req0 = 1'b0; wdata0 = 16'h0000;
    chk("ws0 write ack", 32'(ack0), 1);
    chk("ws0 write busy", 32'(busy0), 1);
    @(negedge clk);
    chk("ws0 write ack drop", 32'(ack0), 0);
    chk("ws0 write busy drop", 32'(busy0), 0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
    @(negedge clk);
    req0 = 1'b0; addr0 = 4'd0;
    chk("ws0 read ack", 32'(ack0), 1);
    chk("ws0 read busy", 32'(busy0), 1);
    chk("ws0 read rdata", 32'(rdata0), 32'hA5C3);
    chk("ws0 read err", 32'(err0), 0);
    @(negedge clk);
    chk("ws0 read ack drop", 32'(ack0), 0);
    chk("ws0 read busy drop", 32'(busy0), 0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd12;
    @(negedge clk);
    req0 = 1'b0;
    chk("ws0 oor ack", 32'(ack0), 1);
    chk("ws0 oor err", 32'(err0), 1);
    chk("ws0 oor rdata", 32'(rdata0), 0);
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_txn(1'b0, 4'(i), 2'b00, 16'h0000, final_word(i), 1'b0,
              $sformatf("final word%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
